// File: rtl/codec_i2c_arbiter.sv
// Round-robin arbiter sharing one audio-codec I2C_Controller between two register-write
// requesters, with NACK retry, per-state timeout and per-port done/err pulses.
module codec_i2c_arbiter #(
    parameter logic [7:0] DEV_ADDR    = 8'h34,
    parameter int         MAX_RETRY   = 3,
    parameter int         TIMEOUT_CYC = 1000000,
    parameter int         GO_LOW_CYC  = 5000
) (
    input  logic        CLOCK_50,
    input  logic        iRST_N,
    input  logic        req_a,
    input  logic [6:0]  addr_a,
    input  logic [8:0]  data_a,
    output logic        gnt_a,
    output logic        done_a,
    output logic        err_a,
    input  logic        req_b,
    input  logic [6:0]  addr_b,
    input  logic [8:0]  data_b,
    output logic        gnt_b,
    output logic        done_b,
    output logic        err_b,
    output logic        i2c_go,
    output logic [23:0] i2c_data,
    input  logic        i2c_end,
    input  logic        i2c_ack,
    output logic        busy
);
    localparam int TW = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYC - 1);
    localparam logic [TW-1:0] GAP_LAST = TW'(GO_LOW_CYC - 1);
    localparam logic [TW-1:0] T_MAX    = '1;
    localparam logic [TW-1:0] T_ONE    = TW'(1);
    localparam logic [3:0]    RETRY_MAX = 4'(MAX_RETRY);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] ISSUE     = 3'd1;
    localparam logic [2:0] WAIT_BUSY = 3'd2;
    localparam logic [2:0] WAIT_END  = 3'd3;
    localparam logic [2:0] GAP       = 3'd4;
    localparam logic [2:0] RESP      = 3'd5;

    logic [2:0]    state;
    logic [TW-1:0] timer;
    logic [3:0]    retry_cnt;
    logic          rr_last;   // 0 = A served last, 1 = B
    logic          sel;       // port owning the current transaction
    logic          err_r;
    logic          end_meta, end_s, ack_meta, ack_s;
    logic          pick_a, pick_b;

    // On a tie the port that was not served last wins
    assign pick_a = req_a & (~req_b | rr_last);
    assign pick_b = req_b & (~req_a | ~rr_last);
    assign busy   = (state != IDLE);

    always_ff @(posedge CLOCK_50) begin
        if (!iRST_N) begin
            state     <= IDLE;
            timer     <= '0;
            retry_cnt <= '0;
            rr_last   <= 1'b1;
            sel       <= 1'b0;
            err_r     <= 1'b0;
            end_meta  <= 1'b0;
            end_s     <= 1'b0;
            ack_meta  <= 1'b0;
            ack_s     <= 1'b0;
            i2c_go    <= 1'b0;
            i2c_data  <= '0;
            gnt_a     <= 1'b0;
            gnt_b     <= 1'b0;
            done_a    <= 1'b0;
            done_b    <= 1'b0;
            err_a     <= 1'b0;
            err_b     <= 1'b0;
        end else begin
            end_meta <= i2c_end;
            end_s    <= end_meta;
            ack_meta <= i2c_ack;
            ack_s    <= ack_meta;
            gnt_a    <= 1'b0;
            gnt_b    <= 1'b0;
            done_a   <= 1'b0;
            done_b   <= 1'b0;
            err_a    <= 1'b0;
            err_b    <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_a | pick_b) begin
                        i2c_data  <= pick_a ? {DEV_ADDR, addr_a, data_a} : {DEV_ADDR, addr_b, data_b};
                        gnt_a     <= pick_a;
                        gnt_b     <= pick_b;
                        rr_last   <= pick_b;
                        sel       <= pick_b;
                        retry_cnt <= '0;
                        err_r     <= 1'b0;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    i2c_go <= 1'b1;
                    timer  <= '0;
                    state  <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (!end_s) begin
                        timer <= '0;
                        state <= WAIT_END;
                    end else if (timer == TO_LAST) begin
                        err_r <= 1'b1;
                        state <= RESP;
                    end else if (timer != T_MAX) begin
                        timer <= timer + T_ONE;
                    end
                end
                WAIT_END: begin
                    if (end_s) begin
                        if (!ack_s) begin
                            state <= RESP;
                        end else if (retry_cnt < RETRY_MAX) begin
                            retry_cnt <= retry_cnt + 4'd1;
                            i2c_go    <= 1'b0;
                            timer     <= '0;
                            state     <= GAP;
                        end else begin
                            err_r <= 1'b1;
                            state <= RESP;
                        end
                    end else if (timer == TO_LAST) begin
                        err_r <= 1'b1;
                        state <= RESP;
                    end else if (timer != T_MAX) begin
                        timer <= timer + T_ONE;
                    end
                end
                // GO stays low long enough for the slow controller clock to see the drop
                GAP: begin
                    if (timer >= GAP_LAST) state <= ISSUE;
                    else                   timer <= timer + T_ONE;
                end
                RESP: begin
                    i2c_go <= 1'b0;
                    done_a <= ~sel;
                    done_b <= sel;
                    err_a  <= ~sel & err_r;
                    err_b  <= sel & err_r;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/codec_i2c_arbiter.md
Name: codec_i2c_arbiter

Overview:
Shares the single audio-codec I2C_Controller between two register-write requesters. Port A is the boot/config sequencer; port B is the runtime control path (volume, mic/line select). Each request is a 7-bit codec register address plus 9-bit data. The block arbitrates round-robin, drives the controller's GO/DATA, tracks END/ACK with retry and timeout, and returns a per-requester done/err pulse. Runs on CLOCK_50; the controller runs on its divided I2C control clock.

Parameters:
DEV_ADDR, 8'h34, I2C slave address byte placed in i2c_data[23:16]
MAX_RETRY, 3, NACK retries after the first attempt (0..15)
TIMEOUT_CYC, 1000000, CLOCK_50 cycles allowed in each wait state before abort
GO_LOW_CYC, 5000, cycles i2c_go is held low between retries (>= 2 control-clock periods)

Ports:
CLOCK_50 input 1 system clock, all logic on rising edge
iRST_N input 1 synchronous active-low reset
req_a input 1 port A write request, held until gnt_a
addr_a input 7 port A codec register address
data_a input 9 port A register data
gnt_a output 1 one-cycle pulse: port A fields captured
done_a output 1 one-cycle pulse: port A transaction finished
err_a output 1 valid with done_a: 1 = NACK after all retries, or timeout
req_b, addr_b, data_b, gnt_b, done_b, err_b: same as port A, for port B
i2c_go output 1 GO to I2C_Controller
i2c_data output 24 {DEV_ADDR, addr, data} to I2C_Controller
i2c_end input 1 END from controller (async to CLOCK_50)
i2c_ack input 1 ACK from controller, 1 = NACK seen (async)
busy output 1 high whenever state != IDLE

Behaviour:
- Reset (iRST_N low at a CLOCK_50 edge): state IDLE; i2c_go 0; i2c_data 0; gnt/done/err 0; busy 0; rr_last = B, so A wins the first tie; retry_cnt 0; timer 0; synchronizer flops 0. Reset mid-transaction aborts immediately with no done pulse; the requester re-requests.
- i2c_end and i2c_ack each pass through a 2-flop synchronizer (end_s, ack_s). FSM decisions use only the synchronized values.
- IDLE: if exactly one req is high, grant it. If both are high, grant the port != rr_last. On grant:
  - latch i2c_data = {DEV_ADDR, addr, data};
  - pulse gnt for 1 cycle;
  - set rr_last to the granted port;
  - retry_cnt = 0; go to ISSUE.
  - Latency: req seen at edge N -> gnt high in cycle N+1.
- Request rules: a req dropped before its gnt withdraws the request. Address and data are sampled only at the grant edge and may change afterwards.
- ISSUE: i2c_go = 1; timer = 0; go to WAIT_BUSY.
- WAIT_BUSY: wait for end_s == 0 (controller has started). Then timer = 0 and go to WAIT_END. If timer reaches TIMEOUT_CYC-1, set err and go to RESP.
- WAIT_END: wait for end_s == 1.
  - ack_s == 0: success, go to RESP with err = 0.
  - ack_s == 1 and retry_cnt < MAX_RETRY: retry_cnt++; i2c_go = 0; timer = 0; go to GAP.
  - ack_s == 1 and retry_cnt == MAX_RETRY: go to RESP with err = 1.
  - Timer reaching TIMEOUT_CYC-1: go to RESP with err = 1.
- GAP: i2c_go held 0 for GO_LOW_CYC cycles, then ISSUE. i2c_data is unchanged, so the same write is re-sent.
- RESP: i2c_go = 0; pulse done_x for one cycle with err_x for the granted port; go to IDLE.
  - IDLE can grant again one cycle after RESP.
  - Minimum spacing from done to the next gnt is 1 cycle.
- i2c_data stays stable from grant until the next grant. i2c_go never toggles outside ISSUE, GAP and RESP.
- err_x is 0 whenever done_x is 0. gnt_a/gnt_b and done_a/done_b are never high together.
- timer and retry_cnt saturate and never wrap. Timer width is clog2(TIMEOUT_CYC)+1.

Test Plan:
- Single A write: req_a with addr 7'h04, data 9'd17; controller model drops END 10 cycles after GO, raises END 200 cycles later with ack 0 -> i2c_data = 24'h340811, gnt_a 1 cycle after req, done_a = 1 with err_a = 0, then busy = 0.
- Simultaneous req_a and req_b from reset -> A granted first, B granted the cycle after done_a; a second simultaneous pair is granted to B first (round-robin).
- NACK twice then ACK, MAX_RETRY = 3 -> exactly 3 GO rising edges, each GO-low gap >= GO_LOW_CYC cycles, done with err = 0. Model always NACKs -> 4 GO pulses, then done with err = 1.
- END never falls (TIMEOUT_CYC = 100) -> done pulse with err = 1 at 100 +/- 3 cycles after GO; next request is serviced normally.
- iRST_N asserted low in WAIT_END -> next cycle i2c_go = 0, busy = 0, no done pulse; after release, req_a is granted 1 cycle after it is sampled.
- req_b withdrawn while A is busy -> no gnt_b and no transaction for B.
